// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-requester block memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_WIDTH_DEF  = 16;
  localparam int BLOCK_BYTES_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the requester not served last wins.
import mem_arb_pkg::*;

module mem_rr_pick (
  input  logic [1:0] req,
  input  req_id_t    last_served,
  output logic       valid,
  output req_id_t    winner
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last_served;
    end else if (req[1]) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/mem_block_arbiter.sv
// Arbitrates two block requesters onto one main-memory port with a per-transaction timeout.
import mem_arb_pkg::*;

module mem_block_arbiter #(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int BLOCK_BYTES    = BLOCK_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     r0_req,
  input  logic                     r0_we,
  input  logic [ADDR_WIDTH-1:0]    r0_addr,
  input  logic [BLOCK_BYTES*8-1:0] r0_wdata,
  output logic                     r0_ack,
  output logic                     r0_err,
  output logic [BLOCK_BYTES*8-1:0] r0_rdata,
  input  logic                     r1_req,
  input  logic                     r1_we,
  input  logic [ADDR_WIDTH-1:0]    r1_addr,
  input  logic [BLOCK_BYTES*8-1:0] r1_wdata,
  output logic                     r1_ack,
  output logic                     r1_err,
  output logic [BLOCK_BYTES*8-1:0] r1_rdata,
  output logic [ADDR_WIDTH-1:0]    mem_addr_block,
  output logic [BLOCK_BYTES*8-1:0] mem_wdata_block,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic [BLOCK_BYTES*8-1:0] mem_rdata_block,
  input  logic                     mem_ready,
  output logic                     busy,
  output logic                     grant_id
);

  localparam int DW = BLOCK_BYTES * 8;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  arb_state_t            state_q, state_d;
  req_id_t               last_q, last_d;
  req_id_t               grant_q, grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  tmo_q, tmo_d;
  logic [DW-1:0]         rdata0_q, rdata0_d;
  logic [DW-1:0]         rdata1_q, rdata1_d;

  logic    pick_valid;
  req_id_t pick_winner;

  mem_rr_pick u_pick (
    .req         ({r1_req, r0_req}),
    .last_served (last_q),
    .valid       (pick_valid),
    .winner      (pick_winner)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_winner;
          we_d    = pick_winner ? r1_we    : r0_we;
          addr_d  = pick_winner ? r1_addr  : r0_addr;
          wdata_d = pick_winner ? r1_wdata : r0_wdata;
          tmo_d   = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A ready in the final counted cycle still wins over the timeout.
        if (mem_ready) begin
          if (grant_q) rdata1_d = mem_rdata_block;
          else         rdata0_d = mem_rdata_block;
          state_d = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Handshake outputs decode directly from state so reset clears them at once.
  assign mem_read        = (state_q == ST_ISSUE) && !we_q;
  assign mem_write       = (state_q == ST_ISSUE) &&  we_q;
  assign mem_addr_block  = addr_q;
  assign mem_wdata_block = wdata_q;
  assign r0_ack          = (state_q == ST_RESP) && !tmo_q && !grant_q;
  assign r1_ack          = (state_q == ST_RESP) && !tmo_q &&  grant_q;
  assign r0_err          = (state_q == ST_RESP) &&  tmo_q && !grant_q;
  assign r1_err          = (state_q == ST_RESP) &&  tmo_q &&  grant_q;
  assign r0_rdata        = rdata0_q;
  assign r1_rdata        = rdata1_q;
  assign busy            = (state_q != ST_IDLE);
  assign grant_id        = grant_q;

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Directed bench for mem_block_arbiter against a 4-cycle block memory model.
module tb_mem_block_arbiter;

  localparam int AW = 16;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic          r0_ack, r0_err, r1_ack, r1_err;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] mem_addr_block;
  logic [DW-1:0] mem_wdata_block;
  logic          mem_read, mem_write, busy, grant_id;
  logic [DW-1:0] mem_rdata_block = '0;
  logic          mem_ready = 1'b0;

  int npass = 0;
  int ntot  = 0;
  int cmd_cnt = 0;
  logic ready_en = 1'b1;

  mem_block_arbiter #(.ADDR_WIDTH(16), .BLOCK_BYTES(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_addr_block(mem_addr_block), .mem_wdata_block(mem_wdata_block),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata_block(mem_rdata_block), .mem_ready(mem_ready),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Main memory: 16 blocks, ready pulses 4 cycles after the command cycle.
  logic [DW-1:0] mem [16];
  logic [3:0]    m_idx;
  int            m_ctr;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = {8{32'hC0DE_0000 + 32'(i)}};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ctr     <= 0;
      mem_ready <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      if (mem_read || mem_write) begin
        m_idx <= mem_addr_block[8:5];
        if (mem_write) mem[mem_addr_block[8:5]] = mem_wdata_block;
        m_ctr <= 1;
      end else if (m_ctr == 3) begin
        m_ctr <= 0;
        mem_ready <= ready_en;
        mem_rdata_block <= mem[m_idx];
      end else if (m_ctr != 0) begin
        m_ctr <= m_ctr + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read && mem_write) begin
        ntot++;
        $error("FAIL cmd_overlap: mem_read=%0b mem_write=%0b required not both high", mem_read, mem_write);
      end
      if (mem_read || mem_write) cmd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Raise one request, wait for its ack/err; lat is cycles from request to response.
  task automatic run_txn(input logic id, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, output int lat, output logic got_err,
                         output logic cmd_at1, output logic [DW-1:0] rd);
    lat = -1; got_err = 0; cmd_at1 = 0; rd = '0;
    if (id) begin r1_req = 1; r1_we = we; r1_addr = addr; r1_wdata = wd; end
    else    begin r0_req = 1; r0_we = we; r0_addr = addr; r0_wdata = wd; end
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) cmd_at1 = we ? (mem_write && !mem_read) : (mem_read && !mem_write);
      if ((id ? r1_ack : r0_ack) || (id ? r1_err : r0_err)) begin
        lat = c;
        got_err = id ? r1_err : r0_err;
        rd = id ? r1_rdata : r0_rdata;
        break;
      end
    end
    r0_req = 0; r1_req = 0;
    tick();
  endtask

  int            lat;
  logic          gerr, c1;
  logic [DW-1:0] rd;
  logic [DW-1:0] a5;
  int            seq [4];
  int            nack;
  logic          saw_ack;

  initial begin
    a5 = {32{8'hA5}};
    #1;
    check("reset_outputs", DW'({r0_ack, r1_ack, r0_err, r1_err, mem_read, mem_write, busy, grant_id}), '0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Round-robin: both request together after reset, held continuously.
    cmd_cnt = 0; nack = 0;
    r0_req = 1; r0_we = 0; r0_addr = 16'h0040;
    r1_req = 1; r1_we = 0; r1_addr = 16'h0060;
    for (int c = 0; c < 80 && nack < 4; c++) begin
      tick();
      if (r0_ack) begin seq[nack] = 0; nack++; end
      else if (r1_ack) begin seq[nack] = 1; nack++; end
    end
    r0_req = 0; r1_req = 0;
    tick();
    check("rr_ack_count", DW'(nack), DW'(4));
    check("rr_grant0", DW'(seq[0]), DW'(0));
    check("rr_grant1", DW'(seq[1]), DW'(1));
    check("rr_grant2", DW'(seq[2]), DW'(0));
    check("rr_grant3", DW'(seq[3]), DW'(1));
    check("rr_cmd_count", DW'(cmd_cnt), DW'(4));
    check("rr_r1_rdata", r1_rdata, {8{32'hC0DE_0003}});

    // r0 reads block 2.
    cmd_cnt = 0;
    run_txn(1'b0, 1'b0, 16'h0040, '0, lat, gerr, c1, rd);
    check("rd_cmd_at_r1", DW'(c1), DW'(1));
    check("rd_ack_latency", DW'(lat), DW'(6));
    check("rd_no_err", DW'(gerr), DW'(0));
    check("rd_data_blk2", rd, {8{32'hC0DE_0002}});
    check("rd_cmd_once", DW'(cmd_cnt), DW'(1));
    check("rd_rdata_holds", r0_rdata, {8{32'hC0DE_0002}});

    // r1 writes A5 pattern to 0x0100, r0 reads it back.
    cmd_cnt = 0;
    run_txn(1'b1, 1'b1, 16'h0100, a5, lat, gerr, c1, rd);
    check("wr_cmd_at_r1", DW'(c1), DW'(1));
    check("wr_ack_latency", DW'(lat), DW'(6));
    run_txn(1'b0, 1'b0, 16'h0100, '0, lat, gerr, c1, rd);
    check("wr_rb_data", rd, a5);
    check("wr_cmd_count", DW'(cmd_cnt), DW'(2));

    // Timeout with mem_ready held low.
    ready_en = 1'b0; cmd_cnt = 0; saw_ack = 0; lat = -1;
    r0_req = 1; r0_we = 0; r0_addr = 16'h0020;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (r0_ack) saw_ack = 1;
      if (r0_err) begin lat = c; break; end
    end
    check("tmo_err_cycle", DW'(lat), DW'(18));
    check("tmo_no_ack", DW'(saw_ack || r0_ack), DW'(0));
    r0_req = 0;
    tick();
    check("tmo_busy_after", DW'(busy), DW'(0));
    check("tmo_cmd_once", DW'(cmd_cnt), DW'(1));
    ready_en = 1'b1;

    // Reset while r1's read sits in WAIT.
    saw_ack = 0;
    r1_req = 1; r1_we = 0; r1_addr = 16'h0040;
    tick(); tick(); tick();
    check("rst_busy_before", DW'({busy, grant_id}), DW'(2'b11));
    rst_n = 1'b0;
    #1;
    check("rst_outputs_zero", DW'({r0_ack, r1_ack, r0_err, r1_err, mem_read, mem_write, busy, grant_id}), '0);
    r1_req = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (r1_ack || r1_err) saw_ack = 1;
    end
    rst_n = 1'b1;
    tick();
    check("rst_no_ack", DW'(saw_ack), DW'(0));
    cmd_cnt = 0;
    run_txn(1'b1, 1'b0, 16'h0040, '0, lat, gerr, c1, rd);
    check("rst_after_latency", DW'(lat), DW'(6));
    check("rst_after_data", rd, {8{32'hC0DE_0002}});
    check("rst_after_cmd_once", DW'(cmd_cnt), DW'(1));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/mem_block_arbiter.md
MEM_BLOCK_ARBITER -- requirements
Module: mem_block_arbiter

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- ADDR_WIDTH, 16, byte-address width.
- BLOCK_BYTES, 32, block size in bytes.
- TIMEOUT_CYCLES, 16, maximum cycles to wait for mem_ready.

REQ-002 Ports, one per line (name, direction, width, meaning). Each r{0,1}_ line defines two ports, one per requester.
- clk, in, 1, single clock; all logic is on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- r{0,1}_req, in, 1, request; held high until the matching ack or err.
- r{0,1}_we, in, 1, 1 = block write, 0 = block read; stable while req is high.
- r{0,1}_addr, in, ADDR_WIDTH, block address; stable while req is high.
- r{0,1}_wdata, in, BLOCK_BYTES*8, write block; stable while req is high.
- r{0,1}_ack, out, 1, one-cycle completion pulse.
- r{0,1}_err, out, 1, one-cycle timeout pulse; never asserted together with ack.
- r{0,1}_rdata, out, BLOCK_BYTES*8, read block; valid in the ack cycle of a read.
- mem_addr_block, out, ADDR_WIDTH, address to main memory.
- mem_wdata_block, out, BLOCK_BYTES*8, write data to main memory.
- mem_read, out, 1, read command to main memory.
- mem_write, out, 1, write command to main memory.
- mem_rdata_block, in, BLOCK_BYTES*8, read data from main memory.
- mem_ready, in, 1, one-cycle done pulse from main memory.
- busy, out, 1, high in every state except IDLE.
- grant_id, out, 1, requester currently owning memory.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-004 IDLE, with any req high:
- register the winner into grant_id;
- latch the winner's we, addr and wdata;
- go to ISSUE.
REQ-005 Arbitration SHALL be round-robin:
- one requester requesting: it wins;
- both requesting: the requester not served last wins;
- last_served resets to 1, so r0 wins the first tie.
REQ-006 ISSUE SHALL:
- assert mem_read (we = 0) or mem_write (we = 1) for exactly one cycle, from the latched values;
- drive mem_addr_block and mem_wdata_block from the latched values;
- go to WAIT.
REQ-007 mem_read and mem_write SHALL never be high together, and SHALL be low in every state except ISSUE.
REQ-008 WAIT SHALL count cycles from 0.
- On mem_ready: capture mem_rdata_block into the response register and go to RESP.
- When the count reaches TIMEOUT_CYCLES-1 without mem_ready: set the timeout flag and go to RESP.
REQ-009 RESP SHALL:
- pulse the granted requester's ack (or err, if the timeout flag is set) for one cycle;
- drive its rdata from the response register;
- update last_served to grant_id;
- go to IDLE.
REQ-010 Timing: req first seen in IDLE at cycle R → command in cycle R+1. With a 4-cycle memory (mem_ready at R+5), ack SHALL be at R+6.
REQ-011 A requester SHALL drop req in the cycle after its ack. Because IDLE lasts at least one cycle, a back-to-back request from the same requester is re-arbitrated fairly.
REQ-012 The non-granted requester's req SHALL be ignored until IDLE; its ack and err SHALL stay 0.
REQ-013 A mem_ready arriving outside WAIT SHALL be ignored.
REQ-014 rdata SHALL hold its last value between acks. The rdata of writes and of err responses is don't-care.
REQ-015 The WAIT counter SHALL be $clog2(TIMEOUT_CYCLES)+1 bits wide and SHALL clear on entry to ISSUE.

Reset
REQ-016 When rst_n is low, asynchronously:
- state = IDLE, last_served = 1, grant_id = 0;
- all ack, err, mem_read, mem_write and busy = 0;
- counter, timeout flag and latches = 0.
REQ-017 Reset during ISSUE, WAIT or RESP SHALL abandon the transaction with no ack or err. The system top resets main memory with the same reset, inverted.

Structure
REQ-018 Package mem_arb_pkg SHALL hold:
- the state enum arb_state_t;
- typedef req_id_t (1 bit);
- the defaults for ADDR_WIDTH and BLOCK_BYTES.
REQ-019 One sub-module SHALL exist: mem_rr_pick, a combinational 2-way round-robin picker with inputs req[1:0] and last_served and outputs valid and winner. Everything else lives in mem_block_arbiter.

Verification
REQ-020 Directed scenarios, against the 4-cycle main memory model:
- r0 reads 0x0040 → mem_read pulses once at R+1, r0_ack at R+6, r0_rdata equals memory block 2.
- r1 writes 0x0100 with pattern A5…A5, then r0 reads 0x0100 → r0_rdata = A5…A5.
- r0 and r1 request in the same cycle after reset → r0 served first, then r1; with req held continuously, grants alternate 0,1,0,1.
- mem_ready tied low → err pulses at cycle R+1+TIMEOUT_CYCLES+1; ack stays 0; busy = 0 after.
- rst_n pulsed low during WAIT → all outputs 0 immediately; no ack; next request completes normally.
- Throughout: a checker asserts mem_read and mem_write are never both high and each is at most one cycle per transaction.
